// File: rtl/compare_lock_monitor.sv
// Lock monitor for a 3-flag comparator stream: tracks equal runs, locks after
// LOCK_RUN equal samples, unlocks after UNLOCK_MISS misses, faults on non-one-hot flags.
module compare_lock_monitor #(
  parameter int unsigned LOCK_RUN    = 4,
  parameter int unsigned UNLOCK_MISS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       A_equal_B,
  input  logic       A_greater_B,
  input  logic       A_less_B,
  output logic       locked,
  output logic [1:0] state,
  output logic [3:0] run_len,
  output logic [7:0] eq_count,
  output logic [7:0] gt_count,
  output logic [7:0] lt_count,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_LOCKED = 2'b01,
    ST_FAULT  = 2'b10
  } state_e;

  localparam logic [3:0] LOCK_RUN_L    = 4'(LOCK_RUN);
  localparam logic [2:0] UNLOCK_MISS_L = 3'(UNLOCK_MISS);

  state_e     state_q,  state_d;
  logic       locked_q, locked_d;
  logic [3:0] run_q,    run_d;
  logic [7:0] eq_q,     eq_d;
  logic [7:0] gt_q,     gt_d;
  logic [7:0] lt_q,     lt_d;
  logic [2:0] miss_q,   miss_d;
  logic       err_q,    err_d;

  logic [2:0] flags;
  logic       legal;
  logic [3:0] run_inc;
  logic [2:0] miss_inc;

  assign flags    = {A_equal_B, A_greater_B, A_less_B};
  assign legal    = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign run_inc  = (run_q == 4'd15) ? run_q : run_q + 4'd1;
  assign miss_inc = miss_q + 3'd1;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    state_d = state_q;
    run_d   = run_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    miss_d  = miss_q;
    err_d   = err_q;

    if (clear) begin
      state_d = ST_SEARCH;
      run_d   = '0;
      eq_d    = '0;
      gt_d    = '0;
      lt_d    = '0;
      miss_d  = '0;
      err_d   = 1'b0;
    end else if (in_valid && (state_q != ST_FAULT)) begin
      if (!legal) begin
        err_d   = 1'b1;
        state_d = ST_FAULT;
      end else begin
        if (A_equal_B) begin
          run_d = run_inc;
          if (eq_q != 8'hFF) eq_d = eq_q + 8'd1;
        end else begin
          run_d = '0;
          if (A_greater_B && (gt_q != 8'hFF)) gt_d = gt_q + 8'd1;
          if (A_less_B    && (lt_q != 8'hFF)) lt_d = lt_q + 8'd1;
        end

        case (state_q)
          ST_SEARCH: begin
            if (A_equal_B && (run_inc == LOCK_RUN_L)) state_d = ST_LOCKED;
          end
          ST_LOCKED: begin
            if (A_equal_B) begin
              miss_d = '0;
            end else if (miss_inc == UNLOCK_MISS_L) begin
              state_d = ST_SEARCH;
              miss_d  = '0;
              run_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
          default: ;
        endcase
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // NOTE: reset is synchronous, so it is simply the highest-priority branch
  // inside the clocked block; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      locked_q <= 1'b0;
      run_q    <= '0;
      eq_q     <= '0;
      gt_q     <= '0;
      lt_q     <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      run_q    <= run_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
    end
  end

  assign locked   = locked_q;
  assign state    = state_q;
  assign run_len  = run_q;
  assign eq_count = eq_q;
  assign gt_count = gt_q;
  assign lt_count = lt_q;
  assign err      = err_q;

endmodule
